// File: rtl/ct_clint_apb_arb.sv
// Round-robin arbiter and APB sequencer letting two masters share the CLINT APB slave port.
// Optional build macro CLINT_ARB_TIMEOUT_EN adds a forced-error ACCESS timeout (TIMEOUT_CYC cycles).
//   state  | meaning
//   IDLE   | no transfer; grant a pending requester and latch its payload
//   SETUP  | APB setup phase (psel=1, penable=0), one cycle
//   ACCESS | APB access phase, wait for pready (or timeout)
//   DONE   | one-cycle completion pulse to the granted requester
module ct_clint_apb_arb #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clint_clk,
   input  logic        cpurst_b,
   input  logic        req0_valid,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic        req0_write,
   input  logic [1:0]  req0_prot,
   input  logic        req1_valid,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic        req1_write,
   input  logic [1:0]  req1_prot,
   output logic        done0,
   output logic        done1,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        psel_clint,
   output logic        penable,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic        pwrite,
   output logic [1:0]  pprot,
   input  logic [31:0] prdata_clint,
   input  logic        pready_clint,
   input  logic        perr_clint,
   output logic        arb_busy
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t      r_state, w_nxt;
   logic        r_gnt_id, r_last_gnt;
   logic [31:0] r_paddr, r_pwdata, r_rdata;
   logic        r_pwrite, r_err;
   logic [1:0]  r_pprot;
   logic        w_any, w_win, w_expire, w_fin;

   assign w_any = req0_valid | req1_valid;
   // On contention the requester that was not served last wins.
   assign w_win = (req0_valid & req1_valid) ? ~r_last_gnt : req1_valid;

`ifdef CLINT_ARB_TIMEOUT_EN
   logic [7:0] r_cnt;

   assign w_expire = (r_state == ACCESS) & ~pready_clint & ((r_cnt + 8'd1) == 8'(TIMEOUT_CYC));

   always_ff @(posedge clint_clk or negedge cpurst_b) begin
      if (!cpurst_b)
         r_cnt <= 8'd0;
      else if (r_state == SETUP)
         r_cnt <= 8'd0;
      else if ((r_state == ACCESS) && !pready_clint)
         r_cnt <= r_cnt + 8'd1;
   end
`else
   assign w_expire = 1'b0;
`endif

   assign w_fin = pready_clint | w_expire;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_nxt = SETUP;
         SETUP:   w_nxt = ACCESS;
         ACCESS:  if (w_fin) w_nxt = DONE;
         DONE:    w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clint_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state    <= IDLE;
         r_gnt_id   <= 1'b0;
         r_last_gnt <= 1'b1;
         r_paddr    <= 32'd0;
         r_pwdata   <= 32'd0;
         r_pwrite   <= 1'b0;
         r_pprot    <= 2'd0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_nxt;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt_id <= w_win;
                  r_paddr  <= w_win ? req1_addr  : req0_addr;
                  r_pwdata <= w_win ? req1_wdata : req0_wdata;
                  r_pwrite <= w_win ? req1_write : req0_write;
                  r_pprot  <= w_win ? req1_prot  : req0_prot;
               end
            end
            ACCESS: begin
               if (pready_clint) begin
                  r_rdata <= prdata_clint;
                  r_err   <= perr_clint;
               end else if (w_expire) begin
                  r_rdata <= 32'd0;
                  r_err   <= 1'b1;
               end
               if (w_fin) r_last_gnt <= r_gnt_id;
            end
            default: ;
         endcase
      end
   end

   assign psel_clint = (r_state == SETUP) | (r_state == ACCESS);
   assign penable    = (r_state == ACCESS);
   assign arb_busy   = (r_state != IDLE);
   assign done0      = (r_state == DONE) & ~r_gnt_id;
   assign done1      = (r_state == DONE) &  r_gnt_id;
   assign paddr      = r_paddr;
   assign pwdata     = r_pwdata;
   assign pwrite     = r_pwrite;
   assign pprot      = r_pprot;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_ct_clint_apb_arb.sv
// Directed bench for ct_clint_apb_arb with a small CLINT-like APB slave (pready one cycle after penable).
module tb_ct_clint_apb_arb;

   logic        clint_clk = 1'b0;
   logic        cpurst_b  = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [31:0] req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
   logic        req0_write = 1'b0, req1_write = 1'b0;
   logic [1:0]  req0_prot = '0, req1_prot = '0;
   logic        done0, done1, resp_err, psel_clint, penable, pwrite, arb_busy;
   logic [31:0] resp_rdata, paddr, pwdata;
   logic [1:0]  pprot;
   logic [31:0] slv_rdata = '0;
   logic        slv_err = 1'b0, slv_hang = 1'b0, pready_clint;

   int n_chk = 0, n_err = 0;
   int lat;
   logic w0, w1;

   always #5 clint_clk = ~clint_clk;

   // Registered pready: high in the second ACCESS cycle, unless the slave is told to hang.
   always_ff @(posedge clint_clk or negedge cpurst_b) begin
      if (!cpurst_b) pready_clint <= 1'b0;
      else           pready_clint <= !slv_hang && psel_clint && penable && !pready_clint;
   end

   ct_clint_apb_arb #(.TIMEOUT_CYC(4)) u_dut (
      .clint_clk(clint_clk), .cpurst_b(cpurst_b),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_write(req0_write), .req0_prot(req0_prot),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_write(req1_write), .req1_prot(req1_prot),
      .done0(done0), .done1(done1), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .psel_clint(psel_clint), .penable(penable), .paddr(paddr), .pwdata(pwdata),
      .pwrite(pwrite), .pprot(pprot),
      .prdata_clint(slv_rdata), .pready_clint(pready_clint), .perr_clint(slv_err),
      .arb_busy(arb_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Counts negedges until a done pulse; lat = -1 if none within max cycles.
   task automatic wait_done(input int max, output int l, output logic d0, output logic d1);
      l = -1; d0 = 1'b0; d1 = 1'b0;
      for (int i = 1; i <= max; i++) begin
         @(negedge clint_clk);
         if (done0 || done1) begin
            l = i; d0 = done0; d1 = done1;
            return;
         end
      end
   endtask

   function automatic logic any_out();
      return |{psel_clint, penable, paddr, pwdata, pwrite, pprot,
               done0, done1, resp_rdata, resp_err, arb_busy};
   endfunction

   initial begin
      repeat (2) @(negedge clint_clk);
      chk("reset_outputs", 32'(any_out()), 32'd0);
      cpurst_b = 1'b1;
      @(negedge clint_clk);

      req0_valid = 1'b1; req0_addr = 32'h4000; req0_wdata = 32'h1234_5678;
      req0_write = 1'b1; req0_prot = 2'b11;
      @(negedge clint_clk);
      chk("t1_setup_psel", 32'({psel_clint, penable}), 32'b10);
      chk("t1_paddr", paddr, 32'h4000);
      chk("t1_pwdata", pwdata, 32'h1234_5678);
      chk("t1_pwrite_pprot", 32'({pwrite, pprot}), 32'b111);
      chk("t1_busy", 32'(arb_busy), 32'd1);
      req0_addr = 32'hFFFF_0000; req0_wdata = 32'h0;
      @(negedge clint_clk);
      chk("t2_access", 32'({psel_clint, penable, pready_clint}), 32'b110);
      chk("t2_payload_stable", paddr, 32'h4000);
      @(negedge clint_clk);
      chk("t3_access_ready", 32'({psel_clint, penable, pready_clint}), 32'b111);
      chk("t3_no_done", 32'({done0, done1}), 32'b00);
      @(negedge clint_clk);
      chk("t4_done0", 32'({done0, done1}), 32'b10);
      chk("t4_err", 32'(resp_err), 32'd0);
      chk("t4_apb_idle", 32'({psel_clint, penable}), 32'b00);
      req0_valid = 1'b0;
      @(negedge clint_clk);
      chk("t5_idle", 32'({done0, done1, arb_busy}), 32'b000);

      req1_valid = 1'b1; req1_addr = 32'hC000; req1_write = 1'b0; req1_prot = 2'b01;
      slv_rdata = 32'h0000_0001;
      wait_done(10, lat, w0, w1);
      chk("rd1_latency", 32'(lat), 32'd4);
      chk("rd1_done1", 32'({w0, w1}), 32'b01);
      chk("rd1_rdata", resp_rdata, 32'h1);
      chk("rd1_paddr_held", paddr, 32'hC000);
      req1_valid = 1'b0;
      @(negedge clint_clk);

      cpurst_b = 1'b0;
      req0_valid = 1'b1; req0_addr = 32'h0100; req0_write = 1'b0;
      req1_valid = 1'b1; req1_addr = 32'h0200;
      @(negedge clint_clk);
      cpurst_b = 1'b1;
      wait_done(10, lat, w0, w1);
      chk("rr_first_done0", 32'({w0, w1}), 32'b10);
      wait_done(10, lat, w0, w1);
      chk("rr_second_gap", 32'(lat), 32'd5);
      chk("rr_second_done1", 32'({w0, w1}), 32'b01);
      wait_done(10, lat, w0, w1);
      chk("rr_third_gap", 32'(lat), 32'd5);
      chk("rr_third_done0", 32'({w0, w1}), 32'b10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clint_clk);

      req0_valid = 1'b1; req0_addr = 32'h0010; req0_write = 1'b0;
      slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b1;
      wait_done(10, lat, w0, w1);
      chk("perr_done0", 32'({w0, w1}), 32'b10);
      chk("perr_err", 32'(resp_err), 32'd1);
      chk("perr_rdata", resp_rdata, 32'hDEAD_BEEF);
      req0_valid = 1'b0;
      @(negedge clint_clk);
      chk("perr_err_held", 32'(resp_err), 32'd1);
      slv_err = 1'b0;

      slv_hang = 1'b1;
      req1_valid = 1'b1; req1_addr = 32'h0020;
`ifdef CLINT_ARB_TIMEOUT_EN
      wait_done(20, lat, w0, w1);
      chk("tmo_latency", 32'(lat), 32'd6);
      chk("tmo_done1", 32'({w0, w1}), 32'b01);
      chk("tmo_err", 32'(resp_err), 32'd1);
      chk("tmo_rdata", resp_rdata, 32'd0);
`else
      wait_done(100, lat, w0, w1);
      chk("hang_no_done", 32'(lat), 32'hFFFF_FFFF);
      chk("hang_still_access", 32'({psel_clint, penable}), 32'b11);
`endif
      req1_valid = 1'b0;
      slv_hang = 1'b0;
      cpurst_b = 1'b0;
      @(negedge clint_clk);
      cpurst_b = 1'b1;
      @(negedge clint_clk);

      req0_valid = 1'b1; req0_addr = 32'h0040; req0_wdata = 32'hA5A5_0001; req0_write = 1'b1;
      repeat (2) @(negedge clint_clk);
      chk("mid_access_pre", 32'({psel_clint, penable}), 32'b11);
      #1 cpurst_b = 1'b0;
      #1 chk("async_rst_outputs", 32'(any_out()), 32'd0);
      @(negedge clint_clk);
      chk("rst_no_done", 32'({done0, done1}), 32'b00);
      cpurst_b = 1'b1;
      wait_done(10, lat, w0, w1);
      chk("post_rst_latency", 32'(lat), 32'd4);
      chk("post_rst_done0", 32'({w0, w1}), 32'b10);
      chk("post_rst_pwdata", pwdata, 32'hA5A5_0001);
      req0_valid = 1'b0;
      @(negedge clint_clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
